vigenere_decryption: RTL and testbench
======================================

# vigenere_decryption

Streaming multi-character-key (Vigenère) decryptor, the parametrised successor to the single-shift Caesar stage in the decryption datapath. Ciphertext arrives one character per valid beat; each character is shifted back by the next key character, cycling through a key of KEY_LEN characters. Two modes are supported: byte-wide modular subtraction, and alphabetic mod-26 with pass-through of non-letters. A terminator character closes a message, resets the key position and raises busy for one flush cycle.

## Interface
- D_WIDTH, 8: character width in bits (alphabetic mode requires D_WIDTH = 8).
- KEY_LEN, 4: number of key characters, ≥ 1 (KEY_LEN = 1 behaves as a Caesar shift).
- ALPHA_MODE, 1: 1 = mod-26 on 'A'..'Z' only; 0 = plain mod-2^D_WIDTH subtraction on every character.
- END_CHAR, 8'h00: message terminator, consumed and never output.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- data_i  input  D_WIDTH  ciphertext character.
- valid_i  input  1  data_i is valid this cycle.
- key  input  KEY_LEN*D_WIDTH  key; character i is key[i*D_WIDTH +: D_WIDTH], character 0 is used first.
- data_o  output  D_WIDTH  plaintext character; 0 whenever valid_o = 0.
- valid_o  output  1  data_o is valid.
- busy  output  1  high during the flush cycle; valid_i is ignored while busy = 1.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: on valid_i = 1, key is captured into an internal key register and the state moves to RUN. That same beat is processed with index 0; END_CHAR is processed as described under RUN.
- RUN: each valid_i beat is decrypted with key_reg character [idx]. The key input is ignored until the next message starts.
- RUN, valid_i = 1 with data_i = END_CHAR: no output is produced (valid_o = 0), idx is cleared to 0, the state moves to FLUSH, and busy = 1.
- FLUSH: lasts exactly one cycle. Any input is ignored. The state then returns to IDLE and busy returns to 0.
- Byte mode (ALPHA_MODE = 0):
  - data_o = data_i − k, where k is the key character; the result wraps mod 2^D_WIDTH.
  - Every character advances idx.
- Alphabetic mode (ALPHA_MODE = 1):
  - Shift s = k − 'A' when k is in 'A'..'Z'; otherwise s = 0.
  - For data_i in 'A'..'Z': d = (data_i − 'A') − s. If d < 0, add 26. Then data_o = 'A' + d.
  - Any other character is passed through unchanged and does not advance idx.
- idx advances from KEY_LEN−1 back to 0 (wrap-around).
- valid_i = 0 beats cause no output and leave idx unchanged.

## Timing
- Reset values: data_o = 0, valid_o = 0, busy = 0, state = IDLE, idx = 0, key_reg = 0.
- Latency is 1 cycle. A beat sampled at edge N appears on data_o/valid_o after edge N. Back-to-back beats give full throughput.
- busy is registered. It goes high after the edge that samples END_CHAR and goes low after the next edge.
- Reset asserted mid-message: all outputs clear immediately (asynchronously). The next valid beat after reset release starts a new message and captures a fresh key.
- A key change during RUN has no effect until after the terminator.

## Test plan
- Alphabetic mode, KEY_LEN = 3, key = "KEY" ('K' in byte 0), input R,I,J,V,S → output H,E,L,L,O on consecutive cycles, each 1 cycle after its input.
- Alphabetic mode, same key, input "RI JVS" → output "HE LLO". The space passes through and does not advance the key ('J' is still decrypted with 'Y').
- Byte mode, KEY_LEN = 3, key bytes {0x03, 0x01, 0x02}, input 0x05 ×4 → 0x02, 0x04, 0x03, 0x02 (wraps to key[0]). Input 0x01 with k = 0x03 → 0xFE.
- Terminator test:
  - Input "RIJ" then 0x00 → no output for 0x00, busy = 1 for exactly one cycle.
  - A valid beat sent during busy is dropped.
  - Then key = "ABC", input 'B' → 'B' (index restarted at 0, new key used).
- Key switched from "KEY" to "ZZZ" after the first character → the remaining "IJVS" still decrypts as "ELLO".
- rst_n pulsed low after "RI" → outputs 0 immediately. The next message "RIJVS" with key "KEY" decrypts to "HELLO" from index 0.

Source files
------------

// File: rtl/vigenere_decryption.sv
// Streaming Vigenere decryptor: one character per valid beat, 1-cycle latency.
// Terminator clears the key index and holds busy for a single flush cycle.
module vigenere_decryption #(
  parameter int                   D_WIDTH    = 8,
  parameter int                   KEY_LEN    = 4,
  parameter bit                   ALPHA_MODE = 1'b1,
  parameter logic [D_WIDTH-1:0]   END_CHAR   = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [D_WIDTH-1:0]         data_i,
  input  logic                       valid_i,
  input  logic [KEY_LEN*D_WIDTH-1:0] key,
  output logic [D_WIDTH-1:0]         data_o,
  output logic                       valid_o,
  output logic                       busy
);

  localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [D_WIDTH-1:0] CH_A = D_WIDTH'(65);
  localparam logic [D_WIDTH-1:0] CH_Z = D_WIDTH'(90);
  localparam logic [D_WIDTH-1:0] MOD  = D_WIDTH'(26);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d, idx_nxt;
  logic [KEY_LEN-1:0][D_WIDTH-1:0]  key_q, key_d, key_sel;
  logic [D_WIDTH-1:0]               k, dec, a, s, data_d;
  logic                             advance, valid_d, busy_d;

  function automatic logic is_upper(input logic [D_WIDTH-1:0] c);
    return (c >= CH_A) && (c <= CH_Z);
  endfunction

  // First beat of a message is decrypted with the live key input (idx is 0 there).
  always_comb begin
    key_sel = (state_q == IDLE) ? key : key_q;
    k       = key_sel[idx_q];
    a       = data_i - CH_A;
    s       = is_upper(k) ? (k - CH_A) : '0;
    dec     = data_i;
    advance = 1'b1;
    if (ALPHA_MODE) begin
      if (is_upper(data_i)) begin
        dec = (a >= s) ? (CH_A + a - s) : (CH_A + a + MOD - s);
      end else begin
        advance = 1'b0;
      end
    end else begin
      dec = data_i - k;
    end
    idx_nxt = (idx_q == IDX_W'(KEY_LEN-1)) ? '0 : idx_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    data_d  = '0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (valid_i) begin
          if (state_q == IDLE) key_d = key;
          if (data_i == END_CHAR) begin
            idx_d   = '0;
            state_d = FLUSH;
            busy_d  = 1'b1;
          end else begin
            state_d = RUN;
            data_d  = dec;
            valid_d = 1'b1;
            if (advance) idx_d = idx_nxt;
          end
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      key_q   <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      data_o  <= data_d;
      valid_o <= valid_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_vigenere_decryption.sv
// Bench for vigenere_decryption: one alphabetic and one byte-mode instance,
// expected characters queued as beats are driven and popped as outputs appear.
module tb_vigenere_decryption;

  localparam logic [23:0] KEY_KEY = 24'h59454B; // 'K','E','Y' from byte 0
  localparam logic [23:0] KEY_ZZZ = 24'h5A5A5A;
  localparam logic [23:0] KEY_ABC = 24'h434241;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a_din, b_din, a_do, b_do;
  logic        a_vin, b_vin, a_vo, b_vo, a_busy, b_busy;
  logic [23:0] a_key, b_key;
  logic [7:0]  a_q[$], b_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  vigenere_decryption #(.D_WIDTH(8), .KEY_LEN(3), .ALPHA_MODE(1'b1), .END_CHAR(8'h00)) u_alpha (
    .clk(clk), .rst_n(rst_n), .data_i(a_din), .valid_i(a_vin), .key(a_key),
    .data_o(a_do), .valid_o(a_vo), .busy(a_busy));

  vigenere_decryption #(.D_WIDTH(8), .KEY_LEN(3), .ALPHA_MODE(1'b0), .END_CHAR(8'h00)) u_byte (
    .clk(clk), .rst_n(rst_n), .data_i(b_din), .valid_i(b_vin), .key(b_key),
    .data_o(b_do), .valid_o(b_vo), .busy(b_busy));

  // Drive one beat, let the DUT sample it, land 1 time unit after the edge.
  task automatic a_beat(input logic [7:0] d, input logic v);
    a_din = d; a_vin = v;
    @(posedge clk); #1;
    a_vin = 1'b0;
  endtask

  task automatic b_beat(input logic [7:0] d, input logic v);
    b_din = d; b_vin = v;
    @(posedge clk); #1;
    b_vin = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_din = 8'h00; a_vin = 1'b0; a_key = KEY_KEY;
    b_din = 8'h00; b_vin = 1'b0; b_key = 24'h020103;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (a_vo !== 1'b0 || a_do !== 8'h00 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_alpha: got valid=%b data=%h busy=%b, want 0 00 0", a_vo, a_do, a_busy);
    end
    total++;
    if (b_vo !== 1'b0 || b_do !== 8'h00 || b_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_byte: got valid=%b data=%h busy=%b, want 0 00 0", b_vo, b_do, b_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alpha_hello;
    string si = "RIJVS", se = "HELLO";
    logic [7:0] e;
    a_key = KEY_KEY;
    for (int i = 0; i < si.len(); i++) begin
      a_q.push_back(se[i]);
      a_beat(si[i], 1'b1);
      e = a_q.pop_front();
      total++;
      if (a_vo !== 1'b1 || a_do !== e) begin
        bad++;
        $display("FAIL hello[%0d]: got valid=%b data=%h, want valid=1 data=%h", i, a_vo, a_do, e);
      end
    end
    a_beat(8'h00, 1'b1);
    a_beat(8'h00, 1'b0);
  endtask

  task automatic test_alpha_space;
    string si = "RI JVS", se = "HE LLO";
    logic [7:0] e;
    a_key = KEY_KEY;
    for (int i = 0; i < si.len(); i++) begin
      a_q.push_back(se[i]);
      a_beat(si[i], 1'b1);
      e = a_q.pop_front();
      total++;
      if (a_vo !== 1'b1 || a_do !== e) begin
        bad++;
        $display("FAIL space[%0d]: got valid=%b data=%h, want valid=1 data=%h", i, a_vo, a_do, e);
      end
    end
    a_beat(8'h00, 1'b1);
    a_beat(8'h00, 1'b0);
  endtask

  task automatic test_terminator;
    string si = "RIJ", se = "HEL";
    logic [7:0] e;
    a_key = KEY_KEY;
    for (int i = 0; i < si.len(); i++) begin
      a_q.push_back(se[i]);
      a_beat(si[i], 1'b1);
      e = a_q.pop_front();
      total++;
      if (a_vo !== 1'b1 || a_do !== e) begin
        bad++;
        $display("FAIL term_msg[%0d]: got valid=%b data=%h, want valid=1 data=%h", i, a_vo, a_do, e);
      end
    end
    a_beat(8'h00, 1'b1);
    total++;
    if (a_vo !== 1'b0 || a_do !== 8'h00 || a_busy !== 1'b1) begin
      bad++;
      $display("FAIL term_end: got valid=%b data=%h busy=%b, want 0 00 1", a_vo, a_do, a_busy);
    end
    a_beat(8'h51, 1'b1); // dropped while busy
    total++;
    if (a_vo !== 1'b0 || a_do !== 8'h00 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL term_drop: got valid=%b data=%h busy=%b, want 0 00 0", a_vo, a_do, a_busy);
    end
    a_key = KEY_ABC;
    a_q.push_back(8'h42);
    a_beat(8'h42, 1'b1);
    e = a_q.pop_front();
    total++;
    if (a_vo !== 1'b1 || a_do !== e) begin
      bad++;
      $display("FAIL term_restart: got valid=%b data=%h, want valid=1 data=%h", a_vo, a_do, e);
    end
    a_beat(8'h00, 1'b1);
    a_beat(8'h00, 1'b0);
  endtask

  task automatic test_key_change;
    string si = "RIJVS", se = "HELLO";
    logic [7:0] e;
    a_key = KEY_KEY;
    for (int i = 0; i < si.len(); i++) begin
      if (i == 1) a_key = KEY_ZZZ;
      a_q.push_back(se[i]);
      a_beat(si[i], 1'b1);
      e = a_q.pop_front();
      total++;
      if (a_vo !== 1'b1 || a_do !== e) begin
        bad++;
        $display("FAIL keychg[%0d]: got valid=%b data=%h, want valid=1 data=%h", i, a_vo, a_do, e);
      end
    end
    a_beat(8'h00, 1'b1);
    a_beat(8'h00, 1'b0);
  endtask

  task automatic test_reset_mid;
    string si = "RIRIJVS", se = "HEHELLO";
    logic [7:0] e;
    a_key = KEY_KEY;
    for (int i = 0; i < si.len(); i++) begin
      if (i == 2) begin
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (a_vo !== 1'b0 || a_do !== 8'h00 || a_busy !== 1'b0) begin
          bad++;
          $display("FAIL rst_async: got valid=%b data=%h busy=%b, want 0 00 0", a_vo, a_do, a_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
      a_q.push_back(se[i]);
      a_beat(si[i], 1'b1);
      e = a_q.pop_front();
      total++;
      if (a_vo !== 1'b1 || a_do !== e) begin
        bad++;
        $display("FAIL rstmid[%0d]: got valid=%b data=%h, want valid=1 data=%h", i, a_vo, a_do, e);
      end
    end
    a_beat(8'h00, 1'b1);
    a_beat(8'h00, 1'b0);
  endtask

  task automatic test_byte_mode;
    logic [7:0] din[6] = '{8'h05, 8'h05, 8'h77, 8'h05, 8'h05, 8'hFF};
    logic       vin[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp[6] = '{8'h02, 8'h04, 8'h00, 8'h03, 8'h02, 8'h00};
    logic [7:0] e;
    b_key = 24'h020103;
    for (int i = 0; i < 6; i++) begin
      if (vin[i]) b_q.push_back(exp[i]);
      b_beat(din[i], vin[i]);
      total++;
      if (vin[i]) begin
        e = b_q.pop_front();
        if (b_vo !== 1'b1 || b_do !== e) begin
          bad++;
          $display("FAIL byte[%0d]: got valid=%b data=%h, want valid=1 data=%h", i, b_vo, b_do, e);
        end
      end else if (b_vo !== 1'b0 || b_do !== 8'h00) begin
        bad++;
        $display("FAIL byte_gap[%0d]: got valid=%b data=%h, want valid=0 data=00", i, b_vo, b_do);
      end
    end
    b_beat(8'h00, 1'b1);
    total++;
    if (b_vo !== 1'b0 || b_busy !== 1'b1) begin
      bad++;
      $display("FAIL byte_end: got valid=%b busy=%b, want 0 1", b_vo, b_busy);
    end
    b_beat(8'h00, 1'b0);
    total++;
    if (b_busy !== 1'b0) begin
      bad++;
      $display("FAIL byte_flush: got busy=%b, want 0", b_busy);
    end
    b_q.push_back(8'hFE);
    b_beat(8'h01, 1'b1);
    e = b_q.pop_front();
    total++;
    if (b_vo !== 1'b1 || b_do !== e) begin
      bad++;
      $display("FAIL byte_wrap: got valid=%b data=%h, want valid=1 data=%h", b_vo, b_do, e);
    end
    b_beat(8'h00, 1'b1);
    b_beat(8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_alpha_hello();
    test_alpha_space();
    test_terminator();
    test_key_change();
    test_reset_mid();
    test_byte_mode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
